// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller:
//   - state_e      : 3-bit FSM state encoding (IDLE/CHECK/OPEN/BACKOFF/LOCKED)
//   - *_DEF        : default values for the controller parameters
//   - imax()       : integer maximum, used to size the shared timer
// -----------------------------------------------------------------------------
package parking_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_LOCKED  = 3'd4
   } state_e;

   localparam int CAPACITY_DEF   = 8;
   localparam int OPEN_TICKS_DEF = 16;
   localparam int MAX_FAILS_DEF  = 3;
   localparam int LOCK_TICKS_DEF = 64;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/parking_timer.sv
// -----------------------------------------------------------------------------
// parking_timer
// Loadable down-counter shared by the OPEN and LOCKED phases. It stops at
// zero rather than wrapping, so a state that lingers past expiry (e.g. a
// vehicle still on the sensor) keeps seeing zero.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset (count -> 0)
//   load     in  load load_val this cycle (has priority over en)
//   load_val in  value to load
//   en       in  decrement by one when nonzero
//   zero     out count is zero
// -----------------------------------------------------------------------------
module parking_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count_q;

   // Count register: load, saturating decrement, or hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
// Gate controller and occupancy tracker downstream of the password check.
// An entry sensed in IDLE (lot not full) spends one cycle in CHECK, where the
// upstream registered allow verdict is sampled. Admissions open the barrier
// for at least OPEN_TICKS cycles and never close it on a present vehicle;
// denials back off until the vehicle leaves, and MAX_FAILS consecutive
// denials lock the entry out for at least LOCK_TICKS cycles.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   entry_sensor in   vehicle present at the entry
//   allow        in   registered password verdict (valid the cycle after sensing)
//   exit_pulse   in   one-cycle pulse per departing vehicle
//   gate_open    out  barrier raise command (registered, state OPEN)
//   alarm        out  lockout active (registered, state LOCKED)
//   full         out  occupancy == CAPACITY, one cycle behind occupancy
//   occupancy    out  current vehicle count
// -----------------------------------------------------------------------------
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int  CAPACITY   = CAPACITY_DEF,
   parameter int  OPEN_TICKS = OPEN_TICKS_DEF,
   parameter int  MAX_FAILS  = MAX_FAILS_DEF,
   parameter int  LOCK_TICKS = LOCK_TICKS_DEF,
   localparam int OCC_W      = $clog2(CAPACITY + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_sensor,
   input  logic             allow,
   input  logic             exit_pulse,
   output logic             gate_open,
   output logic             alarm,
   output logic             full,
   output logic [OCC_W-1:0] occupancy
);

   localparam int FAIL_W   = $clog2(MAX_FAILS + 1);
   localparam int TICK_MAX = imax(OPEN_TICKS, LOCK_TICKS);
   localparam int TIMER_W  = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

   state_e              state_q;
   logic [FAIL_W-1:0]   fail_q;
   logic [FAIL_W-1:0]   fail_d;
   logic [OCC_W-1:0]    occ_q;
   logic                gate_open_q;
   logic                alarm_q;
   logic                full_q;

   logic                lock_now_s;
   logic                occ_inc_s;
   logic                occ_dec_s;
   logic                timer_load_s;
   logic                timer_en_s;
   logic [TIMER_W-1:0]  timer_val_s;
   logic                timer_zero_s;

   // Next fail count, timer control and occupancy up/down requests.
   always_comb begin
      fail_d       = fail_q + FAIL_W'(1);
      lock_now_s   = (state_q == ST_CHECK) && !allow && (fail_d == FAIL_W'(MAX_FAILS));
      // Timer is only loaded on the way into OPEN or LOCKED.
      timer_load_s = (state_q == ST_CHECK) && (allow || lock_now_s);
      timer_val_s  = allow ? TIMER_W'(OPEN_TICKS - 1) : TIMER_W'(LOCK_TICKS - 1);
      timer_en_s   = (state_q == ST_OPEN) || (state_q == ST_LOCKED);
      occ_inc_s    = (state_q == ST_CHECK) && allow;
      occ_dec_s    = exit_pulse && (occ_q != '0);
   end

   parking_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load_s),
      .load_val (timer_val_s),
      .en       (timer_en_s),
      .zero     (timer_zero_s)
   );

   // Gate FSM with registered Moore outputs, fail counter and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fail_q      <= '0;
         occ_q       <= '0;
         gate_open_q <= 1'b0;
         alarm_q     <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A full lot ignores the sensor entirely: no attempt is counted.
               if (entry_sensor && !full_q) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (allow) begin
                  state_q     <= ST_OPEN;
                  gate_open_q <= 1'b1;
                  fail_q      <= '0;
               end else if (lock_now_s) begin
                  state_q <= ST_LOCKED;
                  alarm_q <= 1'b1;
                  fail_q  <= fail_d;
               end else begin
                  state_q <= ST_BACKOFF;
                  fail_q  <= fail_d;
               end
            end
            ST_OPEN: begin
               // Never lower the barrier while a vehicle is on the sensor.
               if (timer_zero_s && !entry_sensor) begin
                  state_q     <= ST_IDLE;
                  gate_open_q <= 1'b0;
               end
            end
            ST_BACKOFF: begin
               // One attempt per vehicle presence.
               if (!entry_sensor) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (timer_zero_s && !entry_sensor) begin
                  state_q <= ST_IDLE;
                  alarm_q <= 1'b0;
                  fail_q  <= '0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               gate_open_q <= 1'b0;
               alarm_q     <= 1'b0;
            end
         endcase

         // Simultaneous admission and exit cancel out; exit at zero is ignored.
         if (occ_inc_s && !occ_dec_s) begin
            occ_q <= occ_q + OCC_W'(1);
         end else if (occ_dec_s && !occ_inc_s) begin
            occ_q <= occ_q - OCC_W'(1);
         end

         full_q <= (occ_q == OCC_W'(CAPACITY));
      end
   end

   assign gate_open = gate_open_q;
   assign alarm     = alarm_q;
   assign full      = full_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
// Directed bench for parking_gate_ctrl with default parameters
// (CAPACITY=8, OPEN_TICKS=16, MAX_FAILS=3, LOCK_TICKS=64). Each step drives
// the inputs, queues the outputs expected after the next rising edge, and
// compares them one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

   typedef struct packed {
      logic       g;
      logic       a;
      logic       f;
      logic [3:0] o;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       entry_sensor;
   logic       allow;
   logic       exit_pulse;
   logic       gate_open;
   logic       alarm;
   logic       full;
   logic [3:0] occupancy;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks;
   int    errors;

   parking_gate_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .entry_sensor (entry_sensor),
      .allow        (allow),
      .exit_pulse   (exit_pulse),
      .gate_open    (gate_open),
      .alarm        (alarm),
      .full         (full),
      .occupancy    (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (gate_open === e.g) else begin
         errors++;
         $error("FAIL %s gate_open got=%0b exp=%0b", t, gate_open, e.g);
      end
      checks++;
      assert (alarm === e.a) else begin
         errors++;
         $error("FAIL %s alarm got=%0b exp=%0b", t, alarm, e.a);
      end
      checks++;
      assert (full === e.f) else begin
         errors++;
         $error("FAIL %s full got=%0b exp=%0b", t, full, e.f);
      end
      checks++;
      assert (occupancy === e.o) else begin
         errors++;
         $error("FAIL %s occupancy got=%0d exp=%0d", t, occupancy, e.o);
      end
   endtask

   task automatic step(input logic s, input logic a, input logic e, input string t,
                       input logic eg, input logic ea, input logic ef, input logic [3:0] eo);
      entry_sensor = s;
      allow        = a;
      exit_pulse   = e;
      exp_q.push_back('{g: eg, a: ea, f: ef, o: eo});
      tag_q.push_back(t);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic check_state(input string t, input logic [2:0] exp_st);
      checks++;
      assert (dut.state_q === exp_st) else begin
         errors++;
         $error("FAIL %s state got=%0d exp=%0d", t, dut.state_q, exp_st);
      end
   endtask

   initial begin
      int occ;
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      entry_sensor = 1'b0;
      allow        = 1'b0;
      exit_pulse   = 1'b0;

      // Reset state
      step(0, 0, 0, "reset", 0, 0, 0, 4'd0);
      step(0, 0, 0, "reset", 0, 0, 0, 4'd0);
      check_state("reset_state", 3'd0);
      reset = 1'b0;
      step(0, 0, 0, "idle_stable", 0, 0, 0, 4'd0);

      // 3-cycle presence, admitted: gate open exactly 16 cycles
      step(1, 0, 0, "t1_check", 0, 0, 0, 4'd0);
      step(1, 1, 0, "t1_open", 1, 0, 0, 4'd1);
      step(1, 0, 0, "t1_hold", 1, 0, 0, 4'd1);
      for (int i = 0; i < 14; i++) step(0, 0, 0, "t1_hold", 1, 0, 0, 4'd1);
      step(0, 0, 0, "t1_close", 0, 0, 0, 4'd1);
      step(0, 0, 0, "t1_idle", 0, 0, 0, 4'd1);

      // Sensor held 30 cycles: gate stays open until the sensor falls
      step(1, 0, 0, "t2_check", 0, 0, 0, 4'd1);
      step(1, 1, 0, "t2_open", 1, 0, 0, 4'd2);
      for (int i = 0; i < 28; i++) step(1, 0, 0, "t2_hold", 1, 0, 0, 4'd2);
      step(0, 0, 0, "t2_close", 0, 0, 0, 4'd2);

      // Two denied presences -> BACKOFF each time
      for (int p = 0; p < 2; p++) begin
         step(1, 0, 0, "t3_deny_chk", 0, 0, 0, 4'd2);
         step(1, 0, 0, "t3_deny_back", 0, 0, 0, 4'd2);
         check_state("t3_backoff", 3'd3);
         step(1, 0, 0, "t3_backoff_hold", 0, 0, 0, 4'd2);
         step(0, 0, 0, "t3_backoff_rel", 0, 0, 0, 4'd2);
         check_state("t3_idle", 3'd0);
      end
      // Third denial -> LOCKED for 64 cycles; a presence during lockout is ignored
      step(1, 0, 0, "t3_deny3_chk", 0, 0, 0, 4'd2);
      step(1, 0, 0, "t3_lock", 0, 1, 0, 4'd2);
      for (int i = 1; i < 64; i++)
         step((i >= 5 && i <= 10), (i == 6), 0, "t3_lock_hold", 0, 1, 0, 4'd2);
      step(0, 0, 0, "t3_unlock", 0, 0, 0, 4'd2);
      // Correct attempt after release
      step(1, 0, 0, "t3_retry_chk", 0, 0, 0, 4'd2);
      step(1, 1, 0, "t3_retry_open", 1, 0, 0, 4'd3);
      for (int i = 0; i < 15; i++) step(0, 0, 0, "t3_retry_hold", 1, 0, 0, 4'd3);
      step(0, 0, 0, "t3_retry_close", 0, 0, 0, 4'd3);

      // Admission at occupancy 3 with a simultaneous exit -> stays 3
      step(1, 0, 0, "t5_chk", 0, 0, 0, 4'd3);
      step(1, 1, 1, "t5_open_exit", 1, 0, 0, 4'd3);
      for (int i = 0; i < 15; i++) step(0, 0, 0, "t5_hold", 1, 0, 0, 4'd3);
      step(0, 0, 0, "t5_close", 0, 0, 0, 4'd3);

      // Fill to capacity: full follows occupancy by one cycle
      for (int k = 0; k < 5; k++) begin
         occ = 3 + k;
         step(1, 0, 0, "t4_fill_chk", 0, 0, 0, 4'(occ));
         occ = occ + 1;
         step(1, 1, 0, "t4_fill_open", 1, 0, 0, 4'(occ));
         for (int i = 0; i < 15; i++) step(0, 0, 0, "t4_fill_hold", 1, 0, (occ == 8), 4'(occ));
         step(0, 0, 0, "t4_fill_close", 0, 0, (occ == 8), 4'(occ));
      end
      // Ninth presence while full: no CHECK, gate closed, fail count untouched
      for (int i = 0; i < 5; i++) step(1, (i == 1), 0, "t4_ninth", 0, 0, 1, 4'd8);
      check_state("t4_ninth_state", 3'd0);
      checks++;
      assert (dut.fail_q === 2'd0) else begin
         errors++;
         $error("FAIL t4_ninth_fail_cnt got=%0d exp=0", dut.fail_q);
      end
      step(0, 0, 0, "t4_ninth_rel", 0, 0, 1, 4'd8);
      // One exit frees a slot
      step(0, 0, 1, "t4_exit", 0, 0, 1, 4'd7);
      step(0, 0, 0, "t4_notfull", 0, 0, 0, 4'd7);
      step(1, 0, 0, "t4_reentry_chk", 0, 0, 0, 4'd7);
      step(1, 1, 0, "t4_reentry_open", 1, 0, 0, 4'd8);
      for (int i = 0; i < 15; i++) step(0, 0, 0, "t4_reentry_hold", 1, 0, 1, 4'd8);
      step(0, 0, 0, "t4_reentry_close", 0, 0, 1, 4'd8);

      // Drain to 4, admit to 5, then reset while the gate is open
      step(0, 0, 1, "t6_exit", 0, 0, 1, 4'd7);
      step(0, 0, 1, "t6_exit", 0, 0, 0, 4'd6);
      step(0, 0, 1, "t6_exit", 0, 0, 0, 4'd5);
      step(0, 0, 1, "t6_exit", 0, 0, 0, 4'd4);
      step(1, 0, 0, "t6_chk", 0, 0, 0, 4'd4);
      step(1, 1, 0, "t6_open", 1, 0, 0, 4'd5);
      for (int i = 0; i < 3; i++) step(0, 0, 0, "t6_hold", 1, 0, 0, 4'd5);
      reset = 1'b1;
      step(0, 0, 0, "t6_reset", 0, 0, 0, 4'd0);
      check_state("t6_reset_state", 3'd0);
      reset = 1'b0;
      step(0, 0, 0, "t6_after_reset", 0, 0, 0, 4'd0);

      // Exit at occupancy 0 is ignored
      step(0, 0, 1, "occ0_exit", 0, 0, 0, 4'd0);
      step(0, 0, 1, "occ0_exit", 0, 0, 0, 4'd0);
      step(0, 0, 0, "occ0_idle", 0, 0, 0, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
